// File: rtl/button_bank_debouncer.sv
// ---------------------------------------------------------------------------
// button_bank_debouncer
//
// Debounces a bank of independent push buttons. Each channel synchronises its
// raw input through two flops, then requires the synchronised level to differ
// from the accepted level for STABLE_CYCLES consecutive cycles before the new
// level is taken. Accepted edges produce one-cycle press/release pulses.
//
// Optional auto-repeat (macro DEBOUNCE_REPEAT_EN): while a button is held,
// btn_repeat pulses REPEAT_DELAY cycles after the press pulse and then every
// REPEAT_PERIOD cycles. Without the macro btn_repeat is tied to 0 and no hold
// counters exist.
//
// Ports:
//   clk_in      in   1         rising-edge clock
//   reset       in   1         asynchronous, active-high reset
//   btn_raw     in   CHANNELS  raw asynchronous button levels
//   btn_level   out  CHANNELS  debounced level
//   btn_press   out  CHANNELS  one-cycle pulse on accepted 0->1
//   btn_release out  CHANNELS  one-cycle pulse on accepted 1->0
//   btn_repeat  out  CHANNELS  one-cycle auto-repeat pulse
// ---------------------------------------------------------------------------
module button_bank_debouncer #(
    parameter int CHANNELS      = 5,
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_raw,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_repeat
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CHANNELS-1:0] accept;
    logic [CNT_W-1:0]    cnt [CHANNELS];

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // A channel accepts its new level on the cycle its counter has already
    // seen STABLE_CYCLES-1 differing cycles and the input still differs.
    always_comb begin
        accept = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            accept[i] = (sync2[i] != btn_level[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                // Any agreeing cycle restarts qualification; the accept
                // check bounds the counter so it never wraps.
                if ((sync2[i] == btn_level[i]) || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            btn_level   <= btn_level ^ accept;
            btn_press   <= accept & sync2;
            btn_release <= accept & ~sync2;
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W  = $clog2(REP_MAX) + 1;
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

    logic [HOLD_W-1:0]   hold [CHANNELS];
    logic [CHANNELS-1:0] repeating;   // first repeat already issued

    // hold restarts at 0 on the press edge, so the pulse lands exactly
    // REPEAT_DELAY (then REPEAT_PERIOD) edges after the previous event.
    // A channel with level 1 that accepts can only be releasing, so the
    // !accept term suppresses any repeat on the release edge.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            btn_repeat <= '0;
            repeating  <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (btn_level[i] && !accept[i]) begin
                    if (hold[i] == (repeating[i] ? PERIOD_LAST : DELAY_LAST)) begin
                        btn_repeat[i] <= 1'b1;
                        hold[i]       <= '0;
                        repeating[i]  <= 1'b1;
                    end else begin
                        btn_repeat[i] <= 1'b0;
                        hold[i]       <= hold[i] + 1'b1;
                    end
                end else begin
                    btn_repeat[i] <= 1'b0;
                    hold[i]       <= '0;
                    repeating[i]  <= 1'b0;
                end
            end
        end
    end
`else
    assign btn_repeat = '0;
`endif

endmodule
